// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the I/D cache main-memory arbiter.
// Imported by memory_arbiter and by anything that inspects its state.
package memory_arbiter_pkg;

    localparam int ARB_ADDR_WIDTH = 28;
    localparam int ARB_DATA_WIDTH = 128;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT_I = 3'd1,
        GRANT_D = 3'd2,
        DONE_I  = 3'd3,
        DONE_D  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the
// instruction-cache (read-only) and data-cache (read/write) miss paths.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
    parameter int DATA_WIDTH = ARB_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [DATA_WIDTH-1:0] i_readdata,
    output logic                  i_busywait,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [DATA_WIDTH-1:0] d_writedata,
    output logic [DATA_WIDTH-1:0] d_readdata,
    output logic                  d_busywait,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    input  logic [DATA_WIDTH-1:0] mem_readdata,
    input  logic                  mem_busywait
);

    arb_state_t            r_state;
    arb_state_t            w_next;
    logic                  r_last;
    logic                  r_first;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_writedata;
    logic [DATA_WIDTH-1:0] r_i_readdata;
    logic [DATA_WIDTH-1:0] r_d_readdata;

    logic w_i_req;
    logic w_d_req;
    logic w_pick;
    logic w_done;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;

    // Under contention the side that did not win last time goes first.
    assign w_pick = (w_i_req & w_d_req) ? ~r_last
                  : (w_d_req ? REQ_D : REQ_I);

    // The first grant cycle is skipped: memory raises busywait with the strobe.
    assign w_done = ~r_first & ~mem_busywait;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_i_req | w_d_req)
                    w_next = (w_pick == REQ_D) ? GRANT_D : GRANT_I;
            end
            GRANT_I: if (w_done) w_next = DONE_I;
            GRANT_D: if (w_done) w_next = DONE_D;
            DONE_I:  w_next = IDLE;
            DONE_D:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state         <= IDLE;
            r_last          <= REQ_I;
            r_first         <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
            r_i_readdata    <= '0;
            r_d_readdata    <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_next == GRANT_I) begin
                        r_first       <= 1'b1;
                        r_mem_read    <= 1'b1;
                        r_mem_address <= i_address;
                    end else if (w_next == GRANT_D) begin
                        r_first       <= 1'b1;
                        r_mem_address <= d_address;
                        if (d_write) begin
                            r_mem_write     <= 1'b1;
                            r_mem_writedata <= d_writedata;
                        end else begin
                            r_mem_read <= 1'b1;
                        end
                    end
                end
                GRANT_I, GRANT_D: begin
                    r_first <= 1'b0;
                    if (w_done) begin
                        r_mem_read      <= 1'b0;
                        r_mem_write     <= 1'b0;
                        r_mem_address   <= '0;
                        r_mem_writedata <= '0;
                        r_last <= (r_state == GRANT_D) ? REQ_D : REQ_I;
                        // A withdrawn (flushed) request keeps its old data.
                        if (r_state == GRANT_I && i_read)
                            r_i_readdata <= mem_readdata;
                        if (r_state == GRANT_D && r_mem_read && d_read)
                            r_d_readdata <= mem_readdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET && r_state == IDLE)
            assert (!(d_read && d_write));
    end

    assign i_busywait    = i_read & (r_state != DONE_I);
    assign d_busywait    = (d_read | d_write) & (r_state != DONE_D);
    assign i_readdata    = r_i_readdata;
    assign d_readdata    = r_d_readdata;
    assign mem_read      = r_mem_read;
    assign mem_write     = r_mem_write;
    assign mem_address   = r_mem_address;
    assign mem_writedata = r_mem_writedata;

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
Shares the single main-memory port between the instruction-cache miss path (read-only) and the data-cache miss path (read/write). It sits between both caches and main memory. Its per-requester busywait outputs feed the instruction-fetch stall logic, which ORs instruction and data busywaits to freeze the PC. When both requesters are pending, arbitration is 2-way round-robin, so neither side starves.

Parameters:
ADDR_WIDTH, 28, block address width (byte address minus 4 offset bits)
DATA_WIDTH, 128, cache block width in bits

Ports:
CLK  in  1  system clock, all state on posedge
RESET  in  1  asynchronous, active-low reset
i_read  in  1  instruction-cache block read request, held until i_busywait falls
i_address  in  ADDR_WIDTH  instruction block address
i_readdata  out  DATA_WIDTH  block returned to instruction cache
i_busywait  out  1  instruction-side stall
d_read  in  1  data-cache block read request
d_write  in  1  data-cache block write-back request
d_address  in  ADDR_WIDTH  data block address
d_writedata  in  DATA_WIDTH  write-back block
d_readdata  out  DATA_WIDTH  block returned to data cache
d_busywait  out  1  data-side stall
mem_read  out  1  main-memory read strobe
mem_write  out  1  main-memory write strobe
mem_address  out  ADDR_WIDTH  main-memory block address
mem_writedata  out  DATA_WIDTH  main-memory write data
mem_readdata  in  DATA_WIDTH  main-memory read data
mem_busywait  in  1  high while the memory transaction is in progress

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE, last_grant=I, all mem_* outputs 0, i_/d_readdata 0. Registered busywaits are 0, so i_busywait/d_busywait reduce to the raw request level.
- States:
  - IDLE
  - GRANT_I
  - GRANT_D
  - DONE_I
  - DONE_D
- mem_read, mem_write, mem_address and mem_writedata are registered. They are driven only in GRANT_* and are 0 in all other states.
- Busywait outputs (combinational):
  - i_busywait = i_read & (state != DONE_I)
  - d_busywait = (d_read | d_write) & (state != DONE_D)
  - A request therefore stalls in the same cycle it is raised.
- IDLE transitions:
  - Only I pending -> GRANT_I.
  - Only D pending -> GRANT_D.
  - Both pending -> grant the side that is not last_grant.
  - On entering GRANT_*, the arbiter latches the address/writedata and sets mem_read (I, or D read) or mem_write (D write).
  - If d_read and d_write are both asserted, it is treated as a write; simulation asserts an error.
- GRANT_x transitions:
  - Memory contract: mem_busywait rises combinationally with the strobe and stays high until the transaction completes.
  - Completion is the first posedge in GRANT_x, after the first grant cycle, at which mem_busywait=0.
  - On completion: capture mem_readdata into x_readdata (reads only), clear the strobes, set last_grant=x, go to DONE_x.
- DONE_x transitions:
  - x_busywait is low for exactly one cycle and x_readdata is valid.
  - Next state is IDLE.
  - The requester must drop its request in this cycle; a request still high re-arbitrates from IDLE as a new transaction.
- Latency: request in cycle 0 -> strobe in cycle 1 -> completion at cycle 1+L for memory latency L -> busywait low in cycle 2+L.
- Request withdrawn mid-grant (flush): the memory transaction runs to completion because it cannot be aborted. Returned data is discarded (x_readdata unchanged), and the FSM still passes DONE_x -> IDLE.
- Address and data changes while granted are ignored (values latched at grant).
- Reset asserted mid-transaction: immediate return to IDLE with strobes 0; memory is assumed reset by the same RESET.
- No combinational path exists from mem_busywait to mem_* outputs.

Decomposition:
- Shared package (e.g. cpu_pkg):
  - state enum: IDLE=3'd0, GRANT_I=3'd1, GRANT_D=3'd2, DONE_I=3'd3, DONE_D=3'd4
  - ADDR_WIDTH/DATA_WIDTH defaults
  - requester-id constants REQ_I=1'b0, REQ_D=1'b1
- Logic is single-module; round-robin pick is one expression. No sub-module.

Test Plan:
- I-only read, addr 28'h0000010, memory latency 5 returning 128'hA5..A5 -> mem_read high cycles 1–6, i_busywait low only in cycle 7, i_readdata=128'hA5..A5, d_busywait stays 0.
- Simultaneous i_read and d_write right after reset -> D granted first (last_grant=I): mem_write with d_writedata. I is served next with mem_read. i_busywait remains high throughout the D transaction.
- Back-to-back contention: both requesters re-request continuously for 4 transactions -> grants alternate D,I,D,I; no side gets two consecutive grants.
- d_read dropped in the 2nd grant cycle -> mem_read held until mem_busywait=0, d_readdata unchanged, FSM passes DONE_D -> IDLE, then a pending i_read is granted.
- RESET pulsed low mid-GRANT_I (cycle 3 of 5) -> mem_read=0 asynchronously, state IDLE. After release, an i_read still held is re-granted from scratch with a full 5-cycle latency.
